// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous SRAM between a fetch port and a load/store port.
// Optional INST_BUF_EN adds a one-entry fetch buffer that bypasses the SRAM on a hit.
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req_i,
   input  logic [19:0] inst_addr_i,
   output logic [31:0] inst_rdata_o,
   output logic        inst_ack_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [19:0] data_addr_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_ack_o,
   output logic        stall_o,
   output logic [19:0] sram_addr_o,
   output logic [31:0] sram_wdata_o,
   output logic        sram_dout_en_o,
   input  logic [31:0] sram_rdata_i,
   output logic        sram_ce_n_o,
   output logic        sram_oe_n_o,
   output logic        sram_we_n_o,
   output logic [3:0]  sram_be_n_o
);

   typedef enum logic [2:0] {
      IDLE, INST_ACC, DATA_RD, DATA_WR, ACK
   } state_e;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        dsel_q, dsel_d;
   logic [31:0] irdata_q, irdata_d;
   logic [31:0] drdata_q, drdata_d;
   logic        last, rd_acc, access, hit;

`ifdef INST_BUF_EN
   logic        bvalid_q, bvalid_d;
   logic [19:0] baddr_q, baddr_d;
   logic [31:0] bdata_q, bdata_d;
   assign hit = bvalid_q && (baddr_q == inst_addr_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         bvalid_q <= 1'b0;
         baddr_q  <= '0;
         bdata_q  <= '0;
      end else begin
         bvalid_q <= bvalid_d;
         baddr_q  <= baddr_d;
         bdata_q  <= bdata_d;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         dsel_q   <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         dsel_q   <= dsel_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

   assign last = (cnt_q == 4'd0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      dsel_d   = dsel_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
`ifdef INST_BUF_EN
      bvalid_d = bvalid_q;
      baddr_d  = baddr_q;
      bdata_d  = bdata_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (data_req_i) begin
               state_d = data_we_i ? DATA_WR : DATA_RD;
               cnt_d   = WAIT_LD;
               addr_d  = data_addr_i;
               be_d    = data_be_i;
               wdata_d = data_wdata_i;
               dsel_d  = 1'b1;
`ifdef INST_BUF_EN
               // A store to the buffered word makes the copy stale
               if (data_we_i && data_addr_i == baddr_q)
                  bvalid_d = 1'b0;
`endif
            end else if (inst_req_i && hit) begin
               state_d = ACK;
               dsel_d  = 1'b0;
`ifdef INST_BUF_EN
               irdata_d = bdata_q;
`endif
            end else if (inst_req_i) begin
               state_d = INST_ACC;
               cnt_d   = WAIT_LD;
               addr_d  = inst_addr_i;
               be_d    = 4'hF;
               wdata_d = '0;
               dsel_d  = 1'b0;
            end
         end
         INST_ACC, DATA_RD, DATA_WR: begin
            if (last) begin
               state_d = ACK;
               if (state_q == INST_ACC) begin
                  irdata_d = sram_rdata_i;
`ifdef INST_BUF_EN
                  bvalid_d = 1'b1;
                  baddr_d  = addr_q;
                  bdata_d  = sram_rdata_i;
`endif
               end
               if (state_q == DATA_RD)
                  drdata_d = sram_rdata_i;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign access = (state_q == INST_ACC) || (state_q == DATA_RD) ||
                   (state_q == DATA_WR);
   assign rd_acc = (state_q == INST_ACC) || (state_q == DATA_RD);

   // The final write cycle releases we_n so data holds past the write edge
   assign sram_ce_n_o    = ~access;
   assign sram_oe_n_o    = ~rd_acc;
   assign sram_we_n_o    = ~((state_q == DATA_WR) && !last);
   assign sram_dout_en_o = (state_q == DATA_WR);
   assign sram_be_n_o    = (state_q == DATA_WR) ? ~be_q :
                           (rd_acc ? 4'b0000 : 4'b1111);
   assign sram_addr_o    = access ? addr_q : '0;
   assign sram_wdata_o   = sram_dout_en_o ? wdata_q : '0;

   assign inst_rdata_o = irdata_q;
   assign data_rdata_o = drdata_q;
   assign inst_ack_o   = (state_q == ACK) && !dsel_q;
   assign data_ack_o   = (state_q == ACK) && dsel_q;
   assign stall_o      = (inst_req_i | data_req_i) & ~(inst_ack_o | data_ack_o);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus queues expected acks, a monitor checks them.
// Build with +define+INST_BUF_EN to exercise the fetch buffer path.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req_i;
   logic [19:0] inst_addr_i;
   logic [31:0] inst_rdata_o;
   logic        inst_ack_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [19:0] data_addr_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic [31:0] data_rdata_o;
   logic        data_ack_o;
   logic        stall_o;
   logic [19:0] sram_addr_o;
   logic [31:0] sram_wdata_o;
   logic        sram_dout_en_o;
   logic [31:0] sram_rdata_i;
   logic        sram_ce_n_o;
   logic        sram_oe_n_o;
   logic        sram_we_n_o;
   logic [3:0]  sram_be_n_o;

   sram_arbiter #(.WAIT_CYCLES(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .inst_req_i    (inst_req_i),
      .inst_addr_i   (inst_addr_i),
      .inst_rdata_o  (inst_rdata_o),
      .inst_ack_o    (inst_ack_o),
      .data_req_i    (data_req_i),
      .data_we_i     (data_we_i),
      .data_addr_i   (data_addr_i),
      .data_be_i     (data_be_i),
      .data_wdata_i  (data_wdata_i),
      .data_rdata_o  (data_rdata_o),
      .data_ack_o    (data_ack_o),
      .stall_o       (stall_o),
      .sram_addr_o   (sram_addr_o),
      .sram_wdata_o  (sram_wdata_o),
      .sram_dout_en_o(sram_dout_en_o),
      .sram_rdata_i  (sram_rdata_i),
      .sram_ce_n_o   (sram_ce_n_o),
      .sram_oe_n_o   (sram_oe_n_o),
      .sram_we_n_o   (sram_we_n_o),
      .sram_be_n_o   (sram_be_n_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_data;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // {ce_n, oe_n, we_n, be_n[3:0], dout_en}
   localparam logic [7:0] CTL_IDLE = 8'b1111_1110;
   localparam logic [7:0] CTL_RD   = 8'b0010_0000;
   localparam logic [7:0] CTL_WR1  = 8'b0101_1001;
   localparam logic [7:0] CTL_WR2  = 8'b0111_1001;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic expect_ack(input bit d, input logic [31:0] r, input int c);
      exp_t e;
      e.is_data = d;
      e.rdata   = r;
      e.cyc     = c;
      exp_q.push_back(e);
   endtask

   task automatic at_neg(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic at_pos(input int c);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < c);
   endtask

   task automatic chk_pins(input string n, input logic [7:0] ctl,
                           input logic [19:0] a, input logic [31:0] wd);
      check({n, "_ctl"}, {sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
                          sram_be_n_o, sram_dout_en_o}, ctl);
      check({n, "_addr"}, sram_addr_o, a);
      check({n, "_wdata"}, sram_wdata_o, wd);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && (inst_ack_o || data_ack_o)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", {inst_ack_o, data_ack_o}, 2'b00);
         end else begin
            e = exp_q.pop_front();
            check("ack_port", {inst_ack_o, data_ack_o},
                  e.is_data ? 2'b01 : 2'b10);
            check("ack_cycle", cyc, e.cyc);
            check("ack_rdata", e.is_data ? data_rdata_o : inst_rdata_o,
                  e.rdata);
         end
      end
   end

   initial begin
      int k, k2;
      rst          = 1'b1;
      inst_req_i   = 1'b0;
      inst_addr_i  = '0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_addr_i  = '0;
      data_be_i    = '0;
      data_wdata_i = '0;
      sram_rdata_i = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_pins("reset", CTL_IDLE, 20'h0, 32'h0);
      check("reset_acks", {inst_ack_o, data_ack_o}, 2'b00);
      check("reset_rdata", {inst_rdata_o, data_rdata_o}, 64'h0);
      check("reset_stall", stall_o, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      at_pos(cyc + 1);

      // load
      k = cyc;
      sram_rdata_i = 32'hDEADBEEF;
      data_req_i   = 1'b1;
      data_addr_i  = 20'h00010;
      expect_ack(1'b1, 32'hDEADBEEF, k + 3);
      at_neg(k);
      check("load_stall", stall_o, 1'b1);
      at_neg(k + 1);
      chk_pins("load_acc1", CTL_RD, 20'h00010, 32'h0);
      at_neg(k + 2);
      chk_pins("load_acc2", CTL_RD, 20'h00010, 32'h0);
      at_neg(k + 3);
      check("load_ack_stall", stall_o, 1'b0);
      at_pos(k + 4);
      data_req_i = 1'b0;
      at_neg(k + 4);
      chk_pins("load_after", CTL_IDLE, 20'h0, 32'h0);
      at_pos(k + 5);

      // store: must not disturb data_rdata_o
      k = cyc;
      sram_rdata_i = 32'hBAD0BAD0;
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_addr_i  = 20'h00020;
      data_be_i    = 4'b0011;
      data_wdata_i = 32'h12345678;
      expect_ack(1'b1, 32'hDEADBEEF, k + 3);
      at_neg(k + 1);
      chk_pins("store_acc1", CTL_WR1, 20'h00020, 32'h12345678);
      at_neg(k + 2);
      chk_pins("store_acc2", CTL_WR2, 20'h00020, 32'h12345678);
      at_pos(k + 4);
      data_req_i = 1'b0;
      data_we_i  = 1'b0;
      at_neg(k + 4);
      chk_pins("store_after", CTL_IDLE, 20'h0, 32'h0);
      at_pos(k + 5);

      // fetch and load together: load wins
      k = cyc;
      sram_rdata_i = 32'hCAFEF00D;
      data_req_i   = 1'b1;
      data_addr_i  = 20'h00030;
      inst_req_i   = 1'b1;
      inst_addr_i  = 20'h00040;
      expect_ack(1'b1, 32'hCAFEF00D, k + 3);
      expect_ack(1'b0, 32'h0BADC0DE, k + 7);
      at_neg(k + 1);
      check("both_addr_data", sram_addr_o, 20'h00030);
      at_neg(k + 3);
      check("both_ack_stall", stall_o, 1'b0);
      at_pos(k + 4);
      data_req_i   = 1'b0;
      sram_rdata_i = 32'h0BADC0DE;
      at_neg(k + 4);
      check("both_wait_stall", stall_o, 1'b1);
      at_neg(k + 5);
      check("both_addr_inst", sram_addr_o, 20'h00040);
      check("both_oe_inst", sram_oe_n_o, 1'b0);
      at_neg(k + 7);
      check("hold_drdata", data_rdata_o, 32'hCAFEF00D);
      at_pos(k + 8);
      inst_req_i = 1'b0;
      at_pos(k + 9);

      // request dropped after one cycle still completes
      k = cyc;
      sram_rdata_i = 32'h5A5AA5A5;
      data_req_i   = 1'b1;
      data_addr_i  = 20'h00060;
      expect_ack(1'b1, 32'h5A5AA5A5, k + 3);
      at_pos(k + 1);
      data_req_i = 1'b0;
      at_neg(k + 2);
      check("early_drop_ce", sram_ce_n_o, 1'b0);
      at_neg(k + 3);
      check("hold_irdata", inst_rdata_o, 32'h0BADC0DE);
      at_pos(k + 5);

      // reset in the second access cycle aborts without ack
      k = cyc;
      sram_rdata_i = 32'h77778888;
      data_req_i   = 1'b1;
      data_addr_i  = 20'h00050;
      at_neg(k + 1);
      check("rst_acc_ce", sram_ce_n_o, 1'b0);
      at_pos(k + 2);
      rst        = 1'b1;
      data_req_i = 1'b0;
      at_pos(k + 3);
      rst = 1'b0;
      at_neg(k + 3);
      chk_pins("rst_mid", CTL_IDLE, 20'h0, 32'h0);
      check("rst_mid_acks", {inst_ack_o, data_ack_o}, 2'b00);
      check("rst_mid_rdata", {inst_rdata_o, data_rdata_o}, 64'h0);
      at_pos(k + 7);

      // fetch twice, store over it, fetch again
      k = cyc;
      sram_rdata_i = 32'h11112222;
      inst_req_i   = 1'b1;
      inst_addr_i  = 20'h00100;
      expect_ack(1'b0, 32'h11112222, k + 3);
      at_pos(k + 4);
      inst_req_i   = 1'b0;
      sram_rdata_i = 32'h33334444;
      at_pos(k + 5);
      k2 = cyc;
      inst_req_i = 1'b1;
`ifdef INST_BUF_EN
      expect_ack(1'b0, 32'h11112222, k2 + 1);
      at_neg(k2);
      check("buf_hit_ce0", sram_ce_n_o, 1'b1);
      at_neg(k2 + 1);
      check("buf_hit_ce1", sram_ce_n_o, 1'b1);
      at_pos(k2 + 2);
      inst_req_i = 1'b0;
`else
      expect_ack(1'b0, 32'h33334444, k2 + 3);
      at_neg(k2 + 1);
      check("refetch_ce", sram_ce_n_o, 1'b0);
      at_pos(k2 + 4);
      inst_req_i = 1'b0;
`endif
      at_pos(cyc + 1);
      k = cyc;
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_addr_i  = 20'h00100;
      data_be_i    = 4'b1111;
      data_wdata_i = 32'hAAAA5555;
      expect_ack(1'b1, 32'h0, k + 3);
      at_pos(k + 4);
      data_req_i = 1'b0;
      data_we_i  = 1'b0;
      at_pos(k + 5);
      k = cyc;
      sram_rdata_i = 32'h9999AAAA;
      inst_req_i   = 1'b1;
      expect_ack(1'b0, 32'h9999AAAA, k + 3);
      at_neg(k + 1);
      chk_pins("fetch_after_store", CTL_RD, 20'h00100, 32'h0);
      at_pos(k + 4);
      inst_req_i = 1'b0;
      at_pos(k + 8);

      check("pending_acks", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
